// File: rtl/puzzle_regfile.sv
// ---------------------------------------------------------------------------
// puzzle_regfile
//
// Purpose:
//   Small register file holding the state of a sliding-tile puzzle. One
//   entry holds the board (6 tiles x 3 bits), one holds a saturating move
//   count, and one holds a move-order word. Every accepted write to the
//   board entry bumps the move count in the same cycle. A two-state FSM
//   (IDLE/CLEAR) wipes the whole array, one entry per cycle, on request.
//   A registered flag reports when the board matches the solved pattern.
//
// Build option:
//   REGFILE_BYPASS_EN - when defined, both read ports forward the data being
//                       written this cycle (including the incremented move
//                       count during a board write). When undefined, reads
//                       return stored contents only.
//
// Ports:
//   clk      in   1       clock, rising edge
//   rst_n    in   1       synchronous active-low reset
//   we       in   1       write request (ignored while busy)
//   dst      in   ADDR_W  write address
//   wdata    in   DATA_W  write data
//   src0     in   ADDR_W  read address, port 0
//   src1     in   ADDR_W  read address, port 1
//   rdata0   out  DATA_W  combinational read data, port 0
//   rdata1   out  DATA_W  combinational read data, port 1
//   cnt      out  DATA_W  stored move-count entry
//   ord      out  DATA_W  stored order entry
//   clr_req  in   1       request full-array clear (ignored while busy)
//   busy     out  1       clear in progress
//   comp     out  1       board equals GOAL, one cycle behind the board
//   cnt_ovf  out  1       sticky move-count saturation flag
// ---------------------------------------------------------------------------
module puzzle_regfile #(
  parameter int                  DATA_W     = 40,
  parameter int                  ADDR_W     = 4,
  parameter int                  BOARD_W    = 18,
  parameter logic [BOARD_W-1:0]  INIT_BOARD = 18'b001_010_100_101_011_000,
  parameter logic [BOARD_W-1:0]  GOAL       = 18'b001_010_011_100_101_000,
  parameter int                  BOARD_IDX  = 0,
  parameter int                  CNT_IDX    = 1,
  parameter int                  ORD_IDX    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] dst,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] src0,
  input  logic [ADDR_W-1:0] src1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic [DATA_W-1:0] cnt,
  output logic [DATA_W-1:0] ord,
  input  logic              clr_req,
  output logic              busy,
  output logic              comp,
  output logic              cnt_ovf
);

  localparam int DEPTH = 2 ** ADDR_W;

  localparam logic [ADDR_W-1:0] BOARD_A  = ADDR_W'(BOARD_IDX);
  localparam logic [ADDR_W-1:0] CNT_A    = ADDR_W'(CNT_IDX);
  localparam logic [ADDR_W-1:0] LAST_A   = ADDR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] BOARD_RST = DATA_W'(INIT_BOARD);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_CLEAR = 1'b1;

  // Flop-based storage: reads are combinational and the whole array
  // needs a defined reset value, so this cannot map onto block RAM.
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [0:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic              r_ovf;
  logic              r_comp;

  logic              w_idle;
  logic              w_wr_acc;
  logic              w_board_wr;
  logic              w_cnt_sat;
  logic              w_clr_last;
  logic [DATA_W-1:0] w_cnt_inc;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_wr_acc   = we && w_idle;
  assign w_board_wr = w_wr_acc && (dst == BOARD_A);
  assign w_clr_last = (r_state == ST_CLEAR) && (r_ptr == LAST_A);

  // Move count saturates at all-ones instead of wrapping.
  assign w_cnt_sat  = &r_mem[CNT_IDX];
  assign w_cnt_inc  = w_cnt_sat ? r_mem[CNT_IDX] : (r_mem[CNT_IDX] + DATA_W'(1));

  // -------------------------------------------------------------------------
  // Storage update. Per entry priority: reset, clear sweep, direct write,
  // then the move-count side effect of a board write. A board write and a
  // direct count write can never coincide since they need different dst.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (!rst_n) begin
        r_mem[i] <= (i == BOARD_IDX) ? BOARD_RST : '0;
      end else if ((r_state == ST_CLEAR) && (r_ptr == ADDR_W'(i))) begin
        r_mem[i] <= (i == BOARD_IDX) ? BOARD_RST : '0;
      end else if (w_wr_acc && (dst == ADDR_W'(i))) begin
        r_mem[i] <= wdata;
      end else if ((i == CNT_IDX) && w_board_wr) begin
        r_mem[i] <= w_cnt_inc;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Clear FSM. The sweep pointer starts at 0 on entry to CLEAR and the FSM
  // leaves CLEAR on the edge that clears the last entry, so busy is high
  // for exactly DEPTH cycles.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (clr_req) begin
            r_state <= ST_CLEAR;
            r_ptr   <= '0;
          end
        end
        ST_CLEAR: begin
          r_ptr <= r_ptr + ADDR_W'(1);
          if (w_clr_last) begin
            r_state <= ST_IDLE;
            r_ptr   <= '0;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_ptr   <= '0;
        end
      endcase
    end
  end

  // Sticky overflow: set by a board write that finds the count saturated,
  // dropped only by reset or by completion of a clear sweep. A direct load
  // of the count entry leaves it alone.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_ovf <= 1'b0;
    end else if (w_clr_last) begin
      r_ovf <= 1'b0;
    end else if (w_board_wr && w_cnt_sat) begin
      r_ovf <= 1'b1;
    end
  end

  // Solved flag sampled from stored board, one cycle behind it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_comp <= 1'b0;
    end else begin
      r_comp <= (r_mem[BOARD_IDX][BOARD_W-1:0] == GOAL);
    end
  end

  // -------------------------------------------------------------------------
  // Read ports
  // -------------------------------------------------------------------------
`ifdef REGFILE_BYPASS_EN
  // Forward this cycle's write data; the direct-write check comes last so
  // it wins, although it cannot overlap the count forward in practice.
  always_comb begin
    rdata0 = r_mem[src0];
    if (w_board_wr && (src0 == CNT_A)) begin
      rdata0 = w_cnt_inc;
    end
    if (w_wr_acc && (src0 == dst)) begin
      rdata0 = wdata;
    end
  end

  always_comb begin
    rdata1 = r_mem[src1];
    if (w_board_wr && (src1 == CNT_A)) begin
      rdata1 = w_cnt_inc;
    end
    if (w_wr_acc && (src1 == dst)) begin
      rdata1 = wdata;
    end
  end
`else
  assign rdata0 = r_mem[src0];
  assign rdata1 = r_mem[src1];
`endif

  assign cnt     = r_mem[CNT_IDX];
  assign ord     = r_mem[ORD_IDX];
  assign busy    = (r_state == ST_CLEAR);
  assign comp    = r_comp;
  assign cnt_ovf = r_ovf;

endmodule

// File: tb/tb_puzzle_regfile.sv
// ---------------------------------------------------------------------------
// tb_puzzle_regfile
//
// Directed self-checking bench for puzzle_regfile (default parameters).
// A table of vectors covers reset readback, board writes with move counting,
// solved detection latency, saturation and the sticky overflow flag. Hand
// written sequences cover the clear sweep, reset during a clear, a write
// coinciding with a clear request, and read forwarding (expectations follow
// REGFILE_BYPASS_EN).
// ---------------------------------------------------------------------------
module tb_puzzle_regfile;

  localparam logic [39:0] INIT = 40'(18'b001_010_100_101_011_000);
  localparam logic [39:0] GOALV = 40'(18'b001_010_011_100_101_000);
  localparam logic [39:0] ONES = {40{1'b1}};

`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic        we;
  logic [3:0]  dst;
  logic [39:0] wdata;
  logic [3:0]  src0;
  logic [3:0]  src1;
  logic [39:0] rdata0;
  logic [39:0] rdata1;
  logic [39:0] cnt;
  logic [39:0] ord;
  logic        clr_req;
  logic        busy;
  logic        comp;
  logic        cnt_ovf;

  int total;
  int bad;

  puzzle_regfile dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .we      (we),
    .dst     (dst),
    .wdata   (wdata),
    .src0    (src0),
    .src1    (src1),
    .rdata0  (rdata0),
    .rdata1  (rdata1),
    .cnt     (cnt),
    .ord     (ord),
    .clr_req (clr_req),
    .busy    (busy),
    .comp    (comp),
    .cnt_ovf (cnt_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        we;
    logic [3:0]  dst;
    logic [39:0] wdata;
    logic [3:0]  s0;
    logic [3:0]  s1;
    logic [39:0] e0;
    logic [39:0] e1;
    logic [39:0] ecnt;
    logic [39:0] eord;
    logic        ebusy;
    logic        ecomp;
    logic        eovf;
  } vec_t;

  vec_t vecs [14];

  function automatic vec_t mk(input logic w, input logic [3:0] d, input logic [39:0] wd,
                              input logic [3:0] a0, input logic [3:0] a1,
                              input logic [39:0] x0, input logic [39:0] x1,
                              input logic [39:0] xc, input logic [39:0] xo,
                              input logic xcomp, input logic xovf);
    vec_t v;
    v.we = w; v.dst = d; v.wdata = wd; v.s0 = a0; v.s1 = a1;
    v.e0 = x0; v.e1 = x1; v.ecnt = xc; v.eord = xo;
    v.ebusy = 1'b0; v.ecomp = xcomp; v.eovf = xovf;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_in();
    we = 1'b0; dst = '0; wdata = '0; clr_req = 1'b0;
  endtask

  int bc;
  int guard;

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    idle_in();
    src0 = '0;
    src1 = '0;

    // Expected values are the pre-edge outputs, i.e. the state left by all
    // earlier vectors. Write vectors read addresses away from dst/count so
    // they hold with or without forwarding.
    //                we    dst   wdata          s0    s1    rdata0 rdata1 cnt   ord           comp  ovf
    vecs[0]  = mk(1'b0, 4'd0, 40'h0,        4'd0, 4'd1, INIT,  40'h0, 40'h0, 40'h0,      1'b0, 1'b0);
    vecs[1]  = mk(1'b1, 4'd0, 40'h111,      4'd4, 4'd5, 40'h0, 40'h0, 40'h0, 40'h0,      1'b0, 1'b0);
    vecs[2]  = mk(1'b1, 4'd0, 40'h222,      4'd4, 4'd5, 40'h0, 40'h0, 40'h1, 40'h0,      1'b0, 1'b0);
    vecs[3]  = mk(1'b1, 4'd0, GOALV,        4'd4, 4'd5, 40'h0, 40'h0, 40'h2, 40'h0,      1'b0, 1'b0);
    vecs[4]  = mk(1'b0, 4'd0, 40'h0,        4'd0, 4'd1, GOALV, 40'h3, 40'h3, 40'h0,      1'b0, 1'b0);
    vecs[5]  = mk(1'b0, 4'd0, 40'h0,        4'd0, 4'd1, GOALV, 40'h3, 40'h3, 40'h0,      1'b1, 1'b0);
    vecs[6]  = mk(1'b1, 4'd2, 40'hABCDE,    4'd4, 4'd5, 40'h0, 40'h0, 40'h3, 40'h0,      1'b1, 1'b0);
    vecs[7]  = mk(1'b0, 4'd0, 40'h0,        4'd2, 4'd0, 40'hABCDE, GOALV, 40'h3, 40'hABCDE, 1'b1, 1'b0);
    vecs[8]  = mk(1'b1, 4'd1, ONES,         4'd0, 4'd2, GOALV, 40'hABCDE, 40'h3, 40'hABCDE, 1'b1, 1'b0);
    vecs[9]  = mk(1'b1, 4'd0, 40'h5,        4'd2, 4'd4, 40'hABCDE, 40'h0, ONES, 40'hABCDE, 1'b1, 1'b0);
    vecs[10] = mk(1'b0, 4'd0, 40'h0,        4'd1, 4'd0, ONES,  40'h5, ONES,  40'hABCDE,  1'b1, 1'b1);
    vecs[11] = mk(1'b0, 4'd0, 40'h0,        4'd1, 4'd0, ONES,  40'h5, ONES,  40'hABCDE,  1'b0, 1'b1);
    vecs[12] = mk(1'b1, 4'd1, 40'h7,        4'd0, 4'd2, 40'h5, 40'hABCDE, ONES, 40'hABCDE, 1'b0, 1'b1);
    vecs[13] = mk(1'b0, 4'd0, 40'h0,        4'd1, 4'd0, 40'h7, 40'h5, 40'h7, 40'hABCDE,  1'b0, 1'b1);

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ---------------- table-driven vectors ----------------
    for (int i = 0; i < 14; i++) begin
      we = vecs[i].we; dst = vecs[i].dst; wdata = vecs[i].wdata;
      src0 = vecs[i].s0; src1 = vecs[i].s1; clr_req = 1'b0;
      #1;
      $display("vec %0d: we=%0b dst=%0d wdata=%h src0=%0d src1=%0d", i, we, dst, wdata, src0, src1);
      chk($sformatf("v%0d rdata0", i), rdata0, vecs[i].e0);
      chk($sformatf("v%0d rdata1", i), rdata1, vecs[i].e1);
      chk($sformatf("v%0d cnt", i), cnt, vecs[i].ecnt);
      chk($sformatf("v%0d ord", i), ord, vecs[i].eord);
      chk($sformatf("v%0d busy", i), 40'(busy), 40'(vecs[i].ebusy));
      chk($sformatf("v%0d comp", i), 40'(comp), 40'(vecs[i].ecomp));
      chk($sformatf("v%0d cnt_ovf", i), 40'(cnt_ovf), 40'(vecs[i].eovf));
      tick();
    end

    // ---------------- full clear with writes during busy ----------------
    idle_in();
    we = 1'b1; dst = 4'd5; wdata = 40'h1234; src0 = 4'd4; src1 = 4'd4;
    tick();
    idle_in();
    src0 = 4'd5;
    #1;
    $display("seq clear: entry5 loaded, requesting clear");
    chk("clr entry5 before", rdata0, 40'h1234);
    clr_req = 1'b1;
    tick();
    clr_req = 1'b0;
    we = 1'b1; dst = 4'd5; wdata = 40'hFFFF;
    bc = 0;
    guard = 0;
    while (busy && guard < 100) begin
      bc++;
      guard++;
      tick();
    end
    idle_in();
    src0 = 4'd5; src1 = 4'd0;
    #1;
    $display("seq clear: busy cycles=%0d", bc);
    chk("clr busy_cycles", 40'(bc), 40'd16);
    chk("clr entry5 after", rdata0, 40'h0);
    chk("clr board after", rdata1, INIT);
    chk("clr cnt_ovf after", 40'(cnt_ovf), 40'h0);
    chk("clr cnt after", cnt, 40'h0);
    chk("clr ord after", ord, 40'h0);
    tick();
    chk("clr comp after", 40'(comp), 40'h0);

    // ---------------- write + clear together, reset mid-clear ----------------
    we = 1'b1; dst = 4'd9; wdata = 40'h99; src0 = 4'd4; src1 = 4'd4;
    tick();
    we = 1'b1; dst = 4'd15; wdata = 40'h77; clr_req = 1'b1;
    tick();
    idle_in();
    src0 = 4'd15; src1 = 4'd9;
    #1;
    $display("seq rst-mid-clear: clear started with write to entry15");
    chk("wc busy", 40'(busy), 40'h1);
    chk("wc entry15", rdata0, 40'h77);
    chk("wc entry9", rdata1, 40'h99);
    bc = 1;
    while (bc < 7) begin
      tick();
      bc++;
    end
    src0 = 4'd9;
    #1;
    chk("mid busy c7", 40'(busy), 40'h1);
    chk("mid entry9 c7", rdata0, 40'h99);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    #1;
    $display("seq rst-mid-clear: reset applied at clear cycle 7");
    chk("rst busy", 40'(busy), 40'h0);
    chk("rst cnt_ovf", 40'(cnt_ovf), 40'h0);
    chk("rst comp", 40'(comp), 40'h0);
    for (int a = 0; a < 16; a++) begin
      src0 = 4'(a);
      #1;
      chk($sformatf("rst entry%0d", a), rdata0, (a == 0) ? INIT : 40'h0);
    end
    tick();
    chk("rst busy stays", 40'(busy), 40'h0);

    // ---------------- read forwarding ----------------
    idle_in();
    we = 1'b1; dst = 4'd3; wdata = 40'hAB; src0 = 4'd3; src1 = 4'd1;
    #1;
    $display("seq bypass: write entry3=AB, bypass=%0b", BYP);
    chk("byp rdata0 same cycle", rdata0, BYP ? 40'hAB : 40'h0);
    tick();
    we = 1'b1; dst = 4'd0; wdata = 40'h1; src0 = 4'd3; src1 = 4'd1;
    #1;
    chk("byp cnt fwd same cycle", rdata1, BYP ? 40'h1 : 40'h0);
    chk("byp entry3 stored", rdata0, 40'hAB);
    tick();
    idle_in();
    #1;
    chk("byp cnt next cycle", rdata1, 40'h1);
    chk("byp cnt port", cnt, 40'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/puzzle_regfile.md
PUZZLE_REGFILE -- requirements
Module: puzzle_regfile

Interface
REQ-001 Parameter DATA_W, default 40, entry width in bits.
REQ-002 Parameter ADDR_W, default 4, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter BOARD_W, default 18, width of the board field: 6 tiles x 3 bits.
REQ-004 Parameter INIT_BOARD, default 18'b001_010_100_101_011_000, board reset/clear value.
REQ-005 Parameter GOAL, default 18'b001_010_011_100_101_000, solved-board pattern.
REQ-006 Parameters BOARD_IDX, default 0; CNT_IDX, default 1; ORD_IDX, default 2; indices of the board, move-count and order entries.
REQ-007 clk  input  1  clock; all state changes on its rising edge.
REQ-008 rst_n  input  1  reset, synchronous, active-low.
REQ-009 we  input  1  write request.
REQ-010 dst  input  ADDR_W  write address.
REQ-011 wdata  input  DATA_W  write data.
REQ-012 src0, src1  input  ADDR_W each  read addresses.
REQ-013 rdata0, rdata1  output  DATA_W each  read data.
REQ-014 cnt, ord  output  DATA_W each  continuous view of entries CNT_IDX and ORD_IDX.
REQ-015 clr_req  input  1  request a full-array clear.
REQ-016 busy  output  1  high while a clear is in progress.
REQ-017 comp  output  1  board equals GOAL (registered).
REQ-018 cnt_ovf  output  1  sticky move-count saturation flag.

Function
REQ-019 Reads SHALL be combinational: rdataN = entry[srcN] with no clock latency.
REQ-020 In IDLE, when we=1, entry[dst] SHALL take wdata at the next edge.
REQ-021 When a write to dst=BOARD_IDX is accepted, entry[CNT_IDX] SHALL increment by 1 on the same edge.
REQ-022 If entry[CNT_IDX] is all-ones, the increment SHALL NOT wrap: the value holds and cnt_ovf is set; cnt_ovf stays set until reset or clear completes.
REQ-023 A direct write to CNT_IDX SHALL load wdata; it does not clear cnt_ovf.
REQ-024 The FSM SHALL have two states: IDLE and CLEAR.
REQ-025 In IDLE, clr_req=1 SHALL move the FSM to CLEAR at the next edge with the pointer at 0; busy = (state==CLEAR).
REQ-026 In CLEAR, one entry SHALL be cleared per cycle in ascending order: BOARD_IDX gets INIT_BOARD zero-extended, all others get 0.
REQ-027 After entry DEPTH-1 is cleared, the FSM SHALL return to IDLE and clear cnt_ovf on that edge; busy stays high for exactly DEPTH cycles.
REQ-028 While busy, we and clr_req SHALL be ignored, with no write and no count increment; reads return current contents.
REQ-029 comp SHALL register (entry[BOARD_IDX][BOARD_W-1:0] == GOAL) every cycle, giving one cycle of latency after the board changes.
REQ-030 When we and clr_req are both high in IDLE, the write SHALL occur and the clear SHALL start on the same edge.

Reset
REQ-031 While rst_n=0 at an edge: entry[BOARD_IDX] = INIT_BOARD zero-extended; all other entries = 0; state = IDLE; pointer = 0; busy = 0; cnt_ovf = 0; comp = 0.
REQ-032 Reset SHALL take priority over every other input, including mid-clear; the clear is abandoned.

Configuration
REQ-033 Macro REGFILE_BYPASS_EN SHALL control read-after-write forwarding.
REQ-034 With REGFILE_BYPASS_EN defined: if a write is accepted and srcN==dst, rdataN = wdata in the same cycle. This also applies to the incremented count when srcN==CNT_IDX during a board write.
REQ-035 With REGFILE_BYPASS_EN undefined: rdataN returns the stored value; new data is visible from the cycle after the edge.

Verification
REQ-036 Reset, then read src0=0 and src1=1 -> rdata0=18'b001_010_100_101_011_000, rdata1=0, comp=0, busy=0.
REQ-037 Three writes to dst=0, the last with GOAL -> cnt=3; comp=1 one cycle after the last write edge.
REQ-038 Write entry 1 = all-ones, then write dst=0 -> cnt stays all-ones and cnt_ovf=1.
REQ-039 Write entry 5 = 0x1234, pulse clr_req, assert we to dst=5 during busy -> busy high 16 cycles; afterwards entry5=0, entry0=INIT_BOARD, cnt_ovf=0.
REQ-040 Assert rst_n=0 at clear cycle 7 -> next cycle busy=0 and all entries hold reset values.
REQ-041 we=1, dst=3, src0=3, wdata=0xAB -> same cycle rdata0=0xAB with REGFILE_BYPASS_EN defined, old value without it.
